ram_1port_arbiter: RTL and testbench



---
 rtl/ram_arb_pkg.sv | 10 +
 rtl/rr_arb_2.sv | 34 +++
 rtl/ram_1port_arbiter.sv | 81 ++++++++
 tb/tb_ram_1port_arbiter.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_arb_pkg.sv
// ram_arb_pkg: requester ids and read-return tag shared by the RAM arbiter
package ram_arb_pkg;
    typedef logic req_id_t;
    localparam req_id_t REQ_A = 1'b0;
    localparam req_id_t REQ_B = 1'b1;
    typedef struct packed {
        logic    valid;
        req_id_t id;
    } rd_tag_t;
endpackage

// File: rtl/rr_arb_2.sv
// rr_arb_2: two-way grant logic, round-robin by default or fixed A-priority
// when RAM_ARB_FIXED_PRIO_EN is defined
module rr_arb_2
    import ram_arb_pkg::*;
(
    input  logic i_Clk,
    input  logic i_Rst,
    input  logic i_A_Req,
    input  logic i_B_Req,
    output logic o_A_Grant,
    output logic o_B_Grant
);
`ifdef RAM_ARB_FIXED_PRIO_EN
    always_comb begin
        o_A_Grant = ~i_Rst & i_A_Req;
        o_B_Grant = ~i_Rst & i_B_Req & ~i_A_Req;
    end
`else
    req_id_t r_Last;
    // on a tie the requester that was not granted last wins
    always_comb begin
        o_A_Grant = ~i_Rst & i_A_Req & (~i_B_Req | (r_Last == REQ_B));
        o_B_Grant = ~i_Rst & i_B_Req & (~i_A_Req | (r_Last == REQ_A));
    end
    always_ff @(posedge i_Clk) begin
        if (i_Rst)
            r_Last <= REQ_B;
        else if (o_A_Grant)
            r_Last <= REQ_A;
        else if (o_B_Grant)
            r_Last <= REQ_B;
    end
`endif
endmodule

// File: rtl/ram_1port_arbiter.sv
// ram_1port_arbiter: shares a single-port RAM between requesters A and B
// Optional RAM_ARB_FIXED_PRIO_EN selects fixed A-priority arbitration
module ram_1port_arbiter
    import ram_arb_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DEPTH = 256,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic             i_Clk,
    input  logic             i_Rst,
    input  logic             i_A_Req,
    input  logic             i_A_Wr,
    input  logic [AW-1:0]    i_A_Addr,
    input  logic [WIDTH-1:0] i_A_Wr_Data,
    output logic             o_A_Ready,
    output logic             o_A_Rd_DV,
    output logic [WIDTH-1:0] o_A_Rd_Data,
    input  logic             i_B_Req,
    input  logic             i_B_Wr,
    input  logic [AW-1:0]    i_B_Addr,
    input  logic [WIDTH-1:0] i_B_Wr_Data,
    output logic             o_B_Ready,
    output logic             o_B_Rd_DV,
    output logic [WIDTH-1:0] o_B_Rd_Data,
    output logic [AW-1:0]    o_Ram_Addr,
    output logic             o_Ram_Wr_DV,
    output logic [WIDTH-1:0] o_Ram_Wr_Data,
    output logic             o_Ram_Rd_En,
    input  logic             i_Ram_Rd_DV,
    input  logic [WIDTH-1:0] i_Ram_Rd_Data
);
    logic    w_A_Grant, w_B_Grant, w_Accept, w_Wr;
    logic    r_Wr_DV, r_Rd_En;
    req_id_t r_Cmd_Id;
    rd_tag_t r_Tag;

    rr_arb_2 u_arb (
        .i_Clk     (i_Clk),
        .i_Rst     (i_Rst),
        .i_A_Req   (i_A_Req),
        .i_B_Req   (i_B_Req),
        .o_A_Grant (w_A_Grant),
        .o_B_Grant (w_B_Grant)
    );

    // strobes are masked by reset so a command already on the port is cancelled
    always_comb begin
        w_Accept      = w_A_Grant | w_B_Grant;
        w_Wr          = w_B_Grant ? i_B_Wr : i_A_Wr;
        o_A_Ready     = w_A_Grant;
        o_B_Ready     = w_B_Grant;
        o_Ram_Wr_DV   = r_Wr_DV & ~i_Rst;
        o_Ram_Rd_En   = r_Rd_En & ~i_Rst;
        o_A_Rd_DV     = i_Ram_Rd_DV & r_Tag.valid & (r_Tag.id == REQ_A);
        o_B_Rd_DV     = i_Ram_Rd_DV & r_Tag.valid & (r_Tag.id == REQ_B);
        o_A_Rd_Data   = i_Ram_Rd_Data;
        o_B_Rd_Data   = i_Ram_Rd_Data;
    end

    // the tag trails the port stage by one cycle to line up with RAM read data
    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            r_Wr_DV       <= 1'b0;
            r_Rd_En       <= 1'b0;
            r_Cmd_Id      <= REQ_A;
            r_Tag         <= '0;
            o_Ram_Addr    <= '0;
            o_Ram_Wr_Data <= '0;
        end else begin
            r_Wr_DV <= w_Accept & w_Wr;
            r_Rd_En <= w_Accept & ~w_Wr;
            r_Tag   <= '{valid: r_Rd_En, id: r_Cmd_Id};
            if (w_Accept) begin
                r_Cmd_Id      <= w_B_Grant ? REQ_B : REQ_A;
                o_Ram_Addr    <= w_B_Grant ? i_B_Addr : i_A_Addr;
                o_Ram_Wr_Data <= w_B_Grant ? i_B_Wr_Data : i_A_Wr_Data;
            end
        end
    end
endmodule

// File: tb/tb_ram_1port_arbiter.sv
// tb_ram_1port_arbiter: scoreboard bench with a 1-cycle-latency RAM model
module tb_ram_1port_arbiter;
    localparam int WIDTH = 16;
    localparam int DEPTH = 256;
    localparam int AW    = 8;
`ifdef RAM_ARB_FIXED_PRIO_EN
    localparam bit FIXED = 1'b1;
`else
    localparam bit FIXED = 1'b0;
`endif

    logic             i_Clk = 1'b0;
    logic             i_Rst = 1'b1;
    logic             i_A_Req = 1'b0, i_A_Wr = 1'b0;
    logic [AW-1:0]    i_A_Addr = '0;
    logic [WIDTH-1:0] i_A_Wr_Data = '0;
    logic             i_B_Req = 1'b0, i_B_Wr = 1'b0;
    logic [AW-1:0]    i_B_Addr = '0;
    logic [WIDTH-1:0] i_B_Wr_Data = '0;
    logic             o_A_Ready, o_A_Rd_DV, o_B_Ready, o_B_Rd_DV;
    logic [WIDTH-1:0] o_A_Rd_Data, o_B_Rd_Data;
    logic [AW-1:0]    o_Ram_Addr;
    logic             o_Ram_Wr_DV, o_Ram_Rd_En;
    logic [WIDTH-1:0] o_Ram_Wr_Data;
    logic             ram_rd_dv = 1'b0;
    logic [WIDTH-1:0] ram_rd_data = '0;

    always #5 i_Clk = ~i_Clk;

    ram_1port_arbiter #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .i_Clk         (i_Clk),
        .i_Rst         (i_Rst),
        .i_A_Req       (i_A_Req),
        .i_A_Wr        (i_A_Wr),
        .i_A_Addr      (i_A_Addr),
        .i_A_Wr_Data   (i_A_Wr_Data),
        .o_A_Ready     (o_A_Ready),
        .o_A_Rd_DV     (o_A_Rd_DV),
        .o_A_Rd_Data   (o_A_Rd_Data),
        .i_B_Req       (i_B_Req),
        .i_B_Wr        (i_B_Wr),
        .i_B_Addr      (i_B_Addr),
        .i_B_Wr_Data   (i_B_Wr_Data),
        .o_B_Ready     (o_B_Ready),
        .o_B_Rd_DV     (o_B_Rd_DV),
        .o_B_Rd_Data   (o_B_Rd_Data),
        .o_Ram_Addr    (o_Ram_Addr),
        .o_Ram_Wr_DV   (o_Ram_Wr_DV),
        .o_Ram_Wr_Data (o_Ram_Wr_Data),
        .o_Ram_Rd_En   (o_Ram_Rd_En),
        .i_Ram_Rd_DV   (ram_rd_dv),
        .i_Ram_Rd_Data (ram_rd_data)
    );

    logic [WIDTH-1:0] mem [DEPTH];
    always @(posedge i_Clk) begin
        if (o_Ram_Wr_DV) mem[o_Ram_Addr] <= o_Ram_Wr_Data;
        ram_rd_dv   <= o_Ram_Rd_En;
        ram_rd_data <= mem[o_Ram_Addr];
    end

    int checks = 0, errors = 0, cyc = 0;
    always @(posedge i_Clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    typedef struct { logic [WIDTH-1:0] data; int cyc; } exp_t;
    exp_t             qa[$], qb[$];
    logic [WIDTH-1:0] shadow [DEPTH];
    logic             pend_v = 1'b0;
    logic [AW-1:0]    pend_a;
    logic [WIDTH-1:0] pend_d;

    // reference model: a write lands one cycle after acceptance unless reset hits
    always @(negedge i_Clk) begin
        exp_t e;
        if (i_Rst) begin
            qa.delete();
            qb.delete();
            pend_v = 1'b0;
        end else begin
            if (pend_v) shadow[pend_a] = pend_d;
            pend_v = 1'b0;
            if (o_A_Rd_DV) begin
                if (qa.size() == 0) check("a_unexp_dv", 1, 0);
                else begin
                    e = qa.pop_front();
                    check("a_rd_data", o_A_Rd_Data, e.data);
                    check("a_rd_cycle", cyc, e.cyc);
                end
            end
            if (o_B_Rd_DV) begin
                if (qb.size() == 0) check("b_unexp_dv", 1, 0);
                else begin
                    e = qb.pop_front();
                    check("b_rd_data", o_B_Rd_Data, e.data);
                    check("b_rd_cycle", cyc, e.cyc);
                end
            end
            if (i_A_Req && o_A_Ready) begin
                if (i_A_Wr) begin pend_v = 1'b1; pend_a = i_A_Addr; pend_d = i_A_Wr_Data; end
                else qa.push_back('{shadow[i_A_Addr], cyc + 2});
            end
            if (i_B_Req && o_B_Ready) begin
                if (i_B_Wr) begin pend_v = 1'b1; pend_a = i_B_Addr; pend_d = i_B_Wr_Data; end
                else qb.push_back('{shadow[i_B_Addr], cyc + 2});
            end
        end
    end

    task automatic next();
        @(posedge i_Clk);
        #1;
    endtask

    task automatic idle(input int n);
        i_A_Req = 1'b0;
        i_B_Req = 1'b0;
        repeat (n) next();
    endtask

    task automatic drive_a(input logic req, input logic wr, input logic [AW-1:0] addr, input logic [WIDTH-1:0] data);
        i_A_Req = req; i_A_Wr = wr; i_A_Addr = addr; i_A_Wr_Data = data;
    endtask

    task automatic drive_b(input logic req, input logic wr, input logic [AW-1:0] addr, input logic [WIDTH-1:0] data);
        i_B_Req = req; i_B_Wr = wr; i_B_Addr = addr; i_B_Wr_Data = data;
    endtask

    task automatic do_reset();
        i_Rst = 1'b1;
        drive_a(1'b1, 1'b0, 8'h00, '0);
        drive_b(1'b1, 1'b0, 8'h00, '0);
        @(negedge i_Clk);
        check("rst_a_ready", o_A_Ready, 0);
        check("rst_b_ready", o_B_Ready, 0);
        next();
        i_Rst = 1'b0;
        idle(1);
    endtask

    logic [WIDTH-1:0] wdata;

    initial begin
        drive_a(1'b1, 1'b1, 8'h00, 16'hFFFF);
        drive_b(1'b1, 1'b0, 8'h00, '0);
        @(negedge i_Clk);
        check("rst_a_ready", o_A_Ready, 0);
        check("rst_b_ready", o_B_Ready, 0);
        check("rst_wr_dv", o_Ram_Wr_DV, 0);
        check("rst_rd_en", o_Ram_Rd_En, 0);
        check("rst_addr", o_Ram_Addr, 0);
        check("rst_wr_data", o_Ram_Wr_Data, 0);
        check("rst_rd_dv", {o_A_Rd_DV, o_B_Rd_DV}, 0);
        next();
        i_Rst = 1'b0;
        idle(1);

        // preload addresses 0..4 and 0x30
        for (int i = 0; i < 6; i++) begin
            drive_a(1'b1, 1'b1, (i < 5) ? AW'(i) : 8'h30, (i < 5) ? WIDTH'(16'hA000 + i) : 16'h1111);
            @(negedge i_Clk);
            check("setup_ready", o_A_Ready, 1);
            next();
        end
        idle(3);

        // tie out of reset: A first, then B, same address
        do_reset();
        drive_a(1'b1, 1'b0, 8'h00, '0);
        drive_b(1'b1, 1'b0, 8'h00, '0);
        @(negedge i_Clk);
        check("tie_a_first", o_A_Ready, 1);
        check("tie_b_wait", o_B_Ready, 0);
        next();
        i_A_Req = 1'b0;
        @(negedge i_Clk);
        check("tie_b_second", o_B_Ready, 1);
        next();
        idle(4);

        // A writes, B reads the same address next cycle
        drive_a(1'b1, 1'b1, 8'h10, 16'h1234);
        @(negedge i_Clk);
        check("raw_a_ready", o_A_Ready, 1);
        next();
        i_A_Req = 1'b0;
        drive_b(1'b1, 1'b0, 8'h10, '0);
        @(negedge i_Clk);
        check("raw_b_ready", o_B_Ready, 1);
        next();
        i_B_Req = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge i_Clk);
            check("raw_no_a_dv", o_A_Rd_DV, 0);
            next();
        end

        // sustained contention: A writes 0x20, B reads it back
        do_reset();
        wdata = 16'h5000;
        drive_a(1'b1, 1'b1, 8'h20, wdata);
        drive_b(1'b1, 1'b0, 8'h20, '0);
        for (int i = 0; i < 8; i++) begin
            @(negedge i_Clk);
            check("rr_a_grant", o_A_Ready, FIXED ? 1 : 32'(i % 2 == 0));
            check("rr_b_grant", o_B_Ready, FIXED ? 0 : 32'(i % 2 == 1));
            if (i > 0) check("rr_port_busy", o_Ram_Rd_En | o_Ram_Wr_DV, 1);
            next();
            if (o_A_Ready) begin wdata = wdata + 16'h1; i_A_Wr_Data = wdata; end
        end
        idle(0);
        @(negedge i_Clk);
        check("rr_port_busy", o_Ram_Rd_En | o_Ram_Wr_DV, 1);
        idle(4);

        // read accepted then reset: its data must never be returned
        drive_a(1'b1, 1'b0, 8'h01, '0);
        @(negedge i_Clk);
        check("rstrd_accept", o_A_Ready, 1);
        next();
        i_Rst = 1'b1;
        @(negedge i_Clk);
        check("rstrd_a_ready", o_A_Ready, 0);
        next();
        i_Rst = 1'b0;
        i_A_Req = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge i_Clk);
            check("rstrd_no_dv", {o_A_Rd_DV, o_B_Rd_DV}, 0);
            next();
        end

        // write accepted then reset: the write must be cancelled
        drive_a(1'b1, 1'b1, 8'h30, 16'hDEAD);
        @(negedge i_Clk);
        check("rstwr_accept", o_A_Ready, 1);
        next();
        i_Rst = 1'b1;
        drive_b(1'b1, 1'b0, 8'h30, '0);
        @(negedge i_Clk);
        check("rstwr_wr_dv", o_Ram_Wr_DV, 0);
        check("rstwr_b_ready", o_B_Ready, 0);
        next();
        i_Rst = 1'b0;
        i_A_Req = 1'b0;
        @(negedge i_Clk);
        check("rstwr_b_read", o_B_Ready, 1);
        next();
        idle(4);
        check("rstwr_mem", mem[8'h30], 16'h1111);

        // B alone streams reads 0..4
        do_reset();
        for (int i = 0; i < 5; i++) begin
            drive_b(1'b1, 1'b0, AW'(i), '0);
            @(negedge i_Clk);
            check("solo_b_ready", o_B_Ready, 1);
            next();
        end
        idle(5);

`ifdef RAM_ARB_FIXED_PRIO_EN
        do_reset();
        drive_a(1'b1, 1'b0, 8'h02, '0);
        drive_b(1'b1, 1'b0, 8'h03, '0);
        for (int i = 0; i < 4; i++) begin
            @(negedge i_Clk);
            check("fix_a_grant", o_A_Ready, 1);
            check("fix_b_grant", o_B_Ready, 0);
            next();
        end
        idle(5);
`endif

        check("a_queue_empty", qa.size(), 0);
        check("b_queue_empty", qb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end
endmodule
